// File: rtl/alu_cmd_driver_if.sv
// Bundle of the command stream, ALU pin and result stream signals of alu_cmd_driver.
// slave:  the driver itself.
// master: everything around the driver (sequencer, ALU, result consumer).
// Optional build macro ALU_DRV_ZFLAG_EN adds the res_zero signal.
interface alu_cmd_driver_if;
  // Command stream
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [2:0] cmd_op;
  // ALU pins
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_sel;
  logic       alu_co;
  logic [3:0] alu_s;
  // Result stream
  logic       res_valid;
  logic       res_ready;
  logic       res_co;
  logic [3:0] res_s;
  logic [2:0] res_op;
`ifdef ALU_DRV_ZFLAG_EN
  logic       res_zero;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_co, alu_s, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_co, res_s, res_op, res_zero
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_co, alu_s, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_co, res_s, res_op, res_zero
  );
`else
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_co, alu_s, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_co, res_s, res_op
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_co, alu_s, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_co, res_s, res_op
  );
`endif
endinterface

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the 4-bit registered ALU.
// Accepts commands on a valid/ready stream, drives ALU operand/select pins, tracks each
// issued op through the ALU pipeline and captures {co,s} into an in-order result FIFO.
// cmd_ready is credit based (FIFO entries + in-flight ops < DEPTH) so captures never drop.
// Optional build macro ALU_DRV_ZFLAG_EN adds a per-entry zero flag on res_zero.
// Assumes LAT >= 1 and DEPTH a power of 2 with DEPTH >= LAT + 1.
module alu_cmd_driver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 2
) (
  input logic             clk,
  input logic             rst,
  alu_cmd_driver_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned NStg = LAT + 1;
  localparam int unsigned IfW  = $clog2(NStg + 1);
  localparam logic [3:0]  SelHold = 4'b1000;

  // Handshake / bookkeeping
  logic            accept;
  logic            push;
  logic            pop;
  logic            cmd_ready;
  logic            res_valid;
  logic [CntW:0]   occupied;

  // ALU pin registers
  logic [3:0]      alu_a_q;
  logic [3:0]      alu_b_q;
  logic [3:0]      alu_sel_q;

  // In-flight tracker
  logic [NStg-1:0] stg_vld_q;
  logic [2:0]      stg_op_q [NStg];
  logic [IfW-1:0]  inflight_q;

  // Result FIFO
  logic [3:0]      mem_s  [DEPTH];
  logic            mem_co [DEPTH];
  logic [2:0]      mem_op [DEPTH];
`ifdef ALU_DRV_ZFLAG_EN
  logic            mem_z  [DEPTH];
`endif
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Credit and handshake decode, from registered state only
  always_comb begin
    occupied  = {1'b0, count_q} + (CntW + 1)'(inflight_q);
    cmd_ready = occupied < (CntW + 1)'(DEPTH);
    res_valid = count_q != '0;
    accept    = bus.cmd_valid & cmd_ready;
    push      = stg_vld_q[NStg-1];
    pop       = res_valid & bus.res_ready;
  end

  // ALU pins: load on accept, otherwise select hold and keep operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= SelHold;
    end else if (accept) begin
      alu_a_q   <= bus.cmd_a;
      alu_b_q   <= bus.cmd_b;
      alu_sel_q <= {1'b0, bus.cmd_op};
    end else begin
      alu_sel_q <= SelHold;
    end
  end

  // Tracker shift register: stage 0 takes this edge's accept, last stage triggers capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld_q <= '0;
      for (int unsigned i = 0; i < NStg; i++) begin
        stg_op_q[i] <= '0;
      end
    end else begin
      stg_vld_q   <= {stg_vld_q[NStg-2:0], accept};
      stg_op_q[0] <= bus.cmd_op;
      for (int unsigned i = 1; i < NStg; i++) begin
        stg_op_q[i] <= stg_op_q[i-1];
      end
    end
  end

  // In-flight count mirrors the number of set tracker valid bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight_q <= inflight_q + IfW'(1);
        2'b01:   inflight_q <= inflight_q - IfW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // FIFO storage: capture the ALU result when the tracked op reaches the last stage.
  // Storage is cleared on reset so the head outputs read back as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_s[i]  <= '0;
        mem_co[i] <= 1'b0;
        mem_op[i] <= '0;
`ifdef ALU_DRV_ZFLAG_EN
        mem_z[i]  <= 1'b0;
`endif
      end
    end else if (push) begin
      mem_s[wr_ptr_q]  <= bus.alu_s;
      mem_co[wr_ptr_q] <= bus.alu_co;
      mem_op[wr_ptr_q] <= stg_op_q[NStg-1];
`ifdef ALU_DRV_ZFLAG_EN
      mem_z[wr_ptr_q]  <= bus.alu_s == 4'd0;
`endif
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_valid = res_valid;
  assign bus.res_co    = mem_co[rd_ptr_q];
  assign bus.res_s     = mem_s[rd_ptr_q];
  assign bus.res_op    = mem_op[rd_ptr_q];
`ifdef ALU_DRV_ZFLAG_EN
  assign bus.res_zero  = mem_z[rd_ptr_q];
`endif

endmodule
